// File: rtl/cypher_pkg.sv
// rtl/cypher_pkg.sv - shared state encoding and code-digit helper for the code-lock detector
package cypher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTER   = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    localparam int CODE_MAX_W  = 256;
    localparam int DIGIT_MAX_W = 32;

    // Digit idx of a code holding `digits` digits of `dw` bits; idx 0 is the most-significant digit.
    function automatic logic [DIGIT_MAX_W-1:0] code_digit(
        input logic [CODE_MAX_W-1:0] code,
        input int                    idx,
        input int                    digits,
        input int                    dw
    );
        logic [CODE_MAX_W-1:0] shifted;
        shifted = code >> ((digits - 1 - idx) * dw);
        shifted = shifted & ((CODE_MAX_W'(1) << dw) - CODE_MAX_W'(1));
        return shifted[DIGIT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/cypher_lockout_timer.sv
// rtl/cypher_lockout_timer.sv - down-counter that flags the last cycle of a lockout window
module cypher_lockout_timer #(
    parameter int LOCK_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    output logic done
);
    localparam int W = $clog2(LOCK_CYCLES + 1);

    logic [W-1:0] count;

    // done is high in the final lockout cycle so the FSM leaves on exactly LOCK_CYCLES cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= W'(LOCK_CYCLES);
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == W'(1));

endmodule

// File: rtl/cypher_detector_seq.sv
// rtl/cypher_detector_seq.sv - code-lock detector with retry budget, timed lockout and abort
module cypher_detector_seq
    import cypher_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 16,
    localparam int SUM_W      = $clog2(DIGITS * (2**DIGIT_W - 1) + 1),
    localparam int CNT_W      = $clog2(DIGITS + 1),
    localparam int TRY_W      = $clog2(MAX_TRIES + 1)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      code_load,
    input  logic [DIGITS*DIGIT_W-1:0] code_in,
    input  logic                      digit_valid,
    input  logic [DIGIT_W-1:0]        digit,
    input  logic                      clear,
    output logic                      right,
    output logic                      wrong,
    output logic                      locked,
    output logic [SUM_W-1:0]          sum,
    output logic [CNT_W-1:0]          digit_cnt,
    output logic [TRY_W-1:0]          tries_left
);
    localparam int CODE_W = DIGITS * DIGIT_W;

    state_t              state;
    logic [CODE_W-1:0]   code;
    logic                mismatch;
    logic                accept;
    logic                first;
    logic                last;
    logic                miss_now;
    logic [DIGIT_W-1:0]  expected;
    logic [SUM_W-1:0]    sum_next;
    logic                timer_load;
    logic                timer_done;

    // In IDLE digit_cnt is always 0, so it doubles as the code index for the incoming digit.
    always_comb begin
        accept     = digit_valid && !clear && (state != ST_LOCKOUT);
        first      = (state == ST_IDLE);
        last       = (digit_cnt == CNT_W'(DIGITS - 1));
        expected   = DIGIT_W'(code_digit(CODE_MAX_W'(code), int'(digit_cnt), DIGITS, DIGIT_W));
        miss_now   = (digit != expected) || (!first && mismatch);
        sum_next   = (first ? '0 : sum) + SUM_W'(digit);
        timer_load = accept && last && miss_now && (tries_left == TRY_W'(1));
    end

    cypher_lockout_timer #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (timer_load),
        .done    (timer_done)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            code       <= '0;
            mismatch   <= 1'b0;
            right      <= 1'b0;
            wrong      <= 1'b0;
            locked     <= 1'b0;
            sum        <= '0;
            digit_cnt  <= '0;
            tries_left <= TRY_W'(MAX_TRIES);
        end else begin
            right <= 1'b0;
            wrong <= 1'b0;
            case (state)
                ST_LOCKOUT: begin
                    if (timer_done) begin
                        state      <= ST_IDLE;
                        locked     <= 1'b0;
                        tries_left <= TRY_W'(MAX_TRIES);
                    end
                end
                default: begin
                    if (first && code_load) begin
                        code <= code_in;
                    end
                    if (clear) begin
                        sum       <= '0;
                        digit_cnt <= '0;
                        mismatch  <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (accept) begin
                        sum      <= sum_next;
                        mismatch <= miss_now;
                        if (last) begin
                            digit_cnt <= '0;
                            right     <= !miss_now;
                            wrong     <= miss_now;
                            state     <= ST_IDLE;
                            if (!miss_now) begin
                                tries_left <= TRY_W'(MAX_TRIES);
                            end else if (tries_left == TRY_W'(1)) begin
                                tries_left <= '0;
                                locked     <= 1'b1;
                                state      <= ST_LOCKOUT;
                            end else begin
                                tries_left <= tries_left - TRY_W'(1);
                            end
                        end else begin
                            digit_cnt <= digit_cnt + CNT_W'(1);
                            state     <= ST_ENTER;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cypher_detector_seq.sv
// tb/tb_cypher_detector_seq.sv - randomized scoreboard bench for cypher_detector_seq
module tb_cypher_detector_seq;
    localparam int DIGITS      = 4;
    localparam int DIGIT_W     = 4;
    localparam int MAX_TRIES   = 3;
    localparam int LOCK_CYCLES = 16;
    localparam int SUM_W       = 6;
    localparam int CNT_W       = 3;
    localparam int TRY_W       = 2;

    logic                      clock = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      code_load = 1'b0;
    logic [DIGITS*DIGIT_W-1:0] code_in = '0;
    logic                      digit_valid = 1'b0;
    logic [DIGIT_W-1:0]        digit = '0;
    logic                      clear = 1'b0;
    logic                      right;
    logic                      wrong;
    logic                      locked;
    logic [SUM_W-1:0]          sum;
    logic [CNT_W-1:0]          digit_cnt;
    logic [TRY_W-1:0]          tries_left;

    cypher_detector_seq #(
        .DIGITS      (DIGITS),
        .DIGIT_W     (DIGIT_W),
        .MAX_TRIES   (MAX_TRIES),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .code_load   (code_load),
        .code_in     (code_in),
        .digit_valid (digit_valid),
        .digit       (digit),
        .clear       (clear),
        .right       (right),
        .wrong       (wrong),
        .locked      (locked),
        .sum         (sum),
        .digit_cnt   (digit_cnt),
        .tries_left  (tries_left)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit ok;
        int total;
        int tries;
        bit lock;
    } result_t;

    result_t exp_q[$];
    int      checks = 0;
    int      errors = 0;

    logic [15:0] m_code;
    int          m_entry[$];
    int          m_want[$];
    int          m_sum;
    int          m_tries;
    int          m_lock_rem;

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
        end
    endtask

    function automatic int cdig(input logic [15:0] c, input int i);
        logic [15:0] s;
        s = c >> (DIGIT_W * (DIGITS - 1 - i));
        return int'(s[3:0]);
    endfunction

    task automatic model_reset();
        m_code     = '0;
        m_entry.delete();
        m_want.delete();
        m_sum      = 0;
        m_tries    = MAX_TRIES;
        m_lock_rem = 0;
    endtask

    task automatic model_edge(input bit v, input int d, input bit c, input bit ld, input logic [15:0] ci);
        bit      idle_now;
        bit      ok;
        result_t r;
        if (m_lock_rem > 0) begin
            m_lock_rem--;
            if (m_lock_rem == 0) m_tries = MAX_TRIES;
            return;
        end
        idle_now = (m_entry.size() == 0);
        if (c) begin
            m_entry.delete();
            m_want.delete();
            m_sum = 0;
        end else if (v) begin
            m_want.push_back(cdig(m_code, m_entry.size()));
            m_sum = idle_now ? d : m_sum + d;
            m_entry.push_back(d);
            if (m_entry.size() == DIGITS) begin
                ok = 1'b1;
                foreach (m_entry[i]) if (m_entry[i] != m_want[i]) ok = 1'b0;
                if (ok) begin
                    m_tries = MAX_TRIES;
                end else begin
                    m_tries--;
                    if (m_tries == 0) m_lock_rem = LOCK_CYCLES;
                end
                r.ok = ok; r.total = m_sum; r.tries = m_tries; r.lock = (m_lock_rem > 0);
                exp_q.push_back(r);
                m_entry.delete();
                m_want.delete();
            end
        end
        if (idle_now && ld) m_code = ci;
    endtask

    task automatic step(input bit v, input int d, input bit c, input bit ld, input logic [15:0] ci);
        digit_valid = v;
        digit       = DIGIT_W'(d);
        clear       = c;
        code_load   = ld;
        code_in     = ci;
        @(posedge clock);
        model_edge(v, d, c, ld, ci);
        #1;
        check("locked", int'(locked), int'(m_lock_rem > 0));
        check("sum", int'(sum), m_sum);
        check("digit_cnt", int'(digit_cnt), m_entry.size());
        check("tries_left", int'(tries_left), m_tries);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic enter(input logic [15:0] code4);
        for (int i = 0; i < DIGITS; i++) step(1'b1, cdig(code4, i), 1'b0, 1'b0, 16'h0);
        idle(1);
    endtask

    task automatic load(input logic [15:0] c);
        step(1'b0, 0, 1'b0, 1'b1, c);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_right"}, int'(right), 0);
        check({tag, "_wrong"}, int'(wrong), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_sum"}, int'(sum), 0);
        check({tag, "_digit_cnt"}, int'(digit_cnt), 0);
        check({tag, "_tries_left"}, int'(tries_left), MAX_TRIES);
    endtask

    // Scoreboard side: every result pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && (right === 1'b1 || wrong === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: right=%0b wrong=%0b with no entry completed at %0t",
                         right, wrong, $time);
            end else begin
                result_t e;
                e = exp_q.pop_front();
                check("pulse_right", int'(right), int'(e.ok));
                check("pulse_wrong", int'(wrong), int'(!e.ok));
                check("pulse_sum", int'(sum), e.total);
                check("pulse_tries", int'(tries_left), e.tries);
                check("pulse_locked", int'(locked), int'(e.lock));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int r;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("reset");
        #1 reset_n = 1'b1;

        load(16'h2601);
        enter(16'h2601);
        enter(16'h2602);
        enter(16'h2601);

        enter(16'h2602);
        enter(16'h1111);
        enter(16'h0000);
        for (int i = 0; i < LOCK_CYCLES; i++) step(1'b1, i % 16, (i % 5) == 0, 1'b1, 16'h1111);
        enter(16'h2601);

        step(1'b1, 2, 1'b0, 1'b0, 16'h0);
        step(1'b1, 6, 1'b0, 1'b0, 16'h0);
        step(1'b1, 0, 1'b1, 1'b0, 16'h0);
        enter(16'h2601);

        step(1'b1, 2, 1'b0, 1'b0, 16'h0);
        step(1'b1, 6, 1'b0, 1'b0, 16'h0);
        load(16'h1111);
        step(1'b1, 0, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1, 1'b0, 1'b0, 16'h0);
        idle(1);
        load(16'h1111);
        enter(16'h1111);

        step(1'b1, 1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1, 1'b0, 1'b0, 16'h0);
        #2 reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        exp_q.delete();
        @(posedge clock);
        #2 reset_n = 1'b1;
        enter(16'h0000);

        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(99);
            if (r < 70 && m_entry.size() < DIGITS) d = cdig(m_code, m_entry.size());
            else d = $urandom_range(15);
            step($urandom_range(99) < 80, d, $urandom_range(99) < 3,
                 $urandom_range(99) < 3, 16'($urandom_range(65535)));
        end

        idle(3);
        check("pending_results", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
